// File: rtl/ones_pattern_pkg.sv
// rtl/ones_pattern_pkg.sv - shared defaults, state encoding and final-pattern helper
// Purpose: default widths for the ones-pattern generator, its controller state
//          type, and last_pat(k), the final (numerically largest) W-bit word
//          holding exactly k ones, i.e. k ones packed into the top bits.
package ones_pattern_pkg;

    localparam int W_DEF  = 8;
    localparam int CW_DEF = 4;
    localparam int IW_DEF = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // (2^W-1) ^ ((1<<(W-k))-1): the low W-k bits clear, the top k bits set.
    function automatic logic [W_DEF-1:0] last_pat(input logic [CW_DEF-1:0] k);
        logic [W_DEF:0] low;
        low = ({{W_DEF{1'b0}}, 1'b1} << (W_DEF - int'(k))) - 1'b1;
        return ~low[W_DEF-1:0];
    endfunction

endpackage

// File: rtl/ones_pattern_gen_comb_next.sv
// rtl/ones_pattern_gen_comb_next.sv - combinational Gosper successor
// Purpose: next larger W-bit word with the same number of ones as x.
// Ports:
//   x    in   W  current word (non-zero)
//   nxt  out  W  successor; only meaningful while x is not the final pattern
module comb_next #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] nxt
);

    localparam int SW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  c;
    logic [W:0]    r;
    logic [SW-1:0] ctz;
    logic [W-1:0]  sh;

    // c isolates the lowest set bit; r ripples it into the next zero above
    // the lowest run of ones. r carries one extra bit so the run boundary
    // is still visible in r^x for the topmost run.
    assign c = x & (~x + 1'b1);
    assign r = {1'b0, x} + {1'b0, c};

    // Index of the single set bit of c; scanning downward lets the lowest
    // set bit win, which is harmless because c has at most one bit set.
    always_comb begin
        ctz = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (c[i]) begin
                ctz = SW'(i);
            end
        end
    end

    // The ones flushed out of the low run are re-packed at the bottom.
    assign sh  = W'((r ^ {1'b0, x}) >> 2) >> ctz;
    assign nxt = r[W-1:0] | sh;

endmodule

// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - enumerates all W-bit words with K ones, ascending
// Purpose: on start with k<=W, streams every W-bit word with exactly k ones
//          in ascending order over a valid/ready handshake; k>W pulses err.
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   start  in   1   request an enumeration; sampled only while idle
//   k      in   CW  requested ones-count, sampled with start
//   ready  in   1   downstream accepts pat this cycle
//   valid  out  1   pat/seq/last valid
//   pat    out  W   current pattern
//   seq    out  IW  0-based index of pat in the enumeration
//   last   out  1   pat is the final pattern
//   busy   out  1   enumeration in progress
//   err    out  1   one-cycle pulse on a rejected start (k>W)
module ones_pattern_gen
    import ones_pattern_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] k,
    input  logic          ready,
    output logic          valid,
    output logic [W-1:0]  pat,
    output logic [IW-1:0] seq,
    output logic          last,
    output logic          busy,
    output logic          err
);

    localparam logic [CW-1:0] KMAX = CW'(W);

    state_t        state;
    logic [CW-1:0] k_q;
    logic [W-1:0]  nxt;
    logic [W-1:0]  first_pat;

    comb_next #(.W(W)) u_next (
        .x   (pat),
        .nxt (nxt)
    );

    // (1<<k)-1 without a W+1-bit intermediate; k==W is the all-ones case.
    assign first_pat = (k == KMAX) ? '1 : (({{(W-1){1'b0}}, 1'b1} << k) - 1'b1);

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k_q   <= '0;
            valid <= 1'b0;
            pat   <= '0;
            seq   <= '0;
            last  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (k > KMAX) begin
                            err <= 1'b1;
                        end else begin
                            k_q   <= k;
                            state <= RUN;
                            valid <= 1'b1;
                            pat   <= first_pat;
                            seq   <= '0;
                            // k==0 and k==W each have exactly one word.
                            last  <= (k == '0) || (k == KMAX);
                        end
                    end
                end
                RUN: begin
                    if (ready) begin
                        if (last) begin
                            state <= IDLE;
                            valid <= 1'b0;
                            last  <= 1'b0;
                        end else begin
                            pat  <= nxt;
                            seq  <= seq + 1'b1;
                            last <= (nxt == last_pat(k_q));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
